// File: rtl/dmem_word_reader_if.sv
// Bus bundle for the data-memory word reader:
// launch controls, memory read port and output stream.
interface dmem_word_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                    start;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic [ADDR_WIDTH-1:0]   count;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_r_addr;
  logic [DATA_WIDTH-1:0]   mem_r_data;
  logic [2*DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    done;

  modport master (
    input  start,
    input  base_addr,
    input  count,
    input  mem_we,
    input  mem_r_data,
    input  out_ready,
    output mem_r_addr,
    output out_data,
    output out_valid,
    output busy,
    output done
  );

  modport slave (
    output start,
    output base_addr,
    output count,
    output mem_we,
    output mem_r_data,
    output out_ready,
    input  mem_r_addr,
    input  out_data,
    input  out_valid,
    input  busy,
    input  done
  );
endinterface

// File: rtl/dmem_word_reader.sv
// Fetches COUNT little-endian 16-bit words from a byte memory
// with a 1-cycle registered read port and streams them out.
module dmem_word_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  dmem_word_reader_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAP_HI,
    OUT
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic [2*DATA_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // The read address register is loaded one state early so that
  // it already points at the byte while RD_LO / RD_HI are active.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    raddr_d = raddr_q;
    lo_d    = lo_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d = bus.base_addr;
          rem_d  = bus.count;
          if (bus.count == '0) begin
            done_d = 1'b1;
          end else begin
            raddr_d = bus.base_addr;
            state_d = RD_LO;
          end
        end
      end
      RD_LO: begin
        if (!bus.mem_we) begin
          raddr_d = addr_q + ONE;
          state_d = RD_HI;
        end
      end
      RD_HI: begin
        if (!bus.mem_we) begin
          lo_d    = bus.mem_r_data;
          state_d = CAP_HI;
        end
      end
      CAP_HI: begin
        data_d  = {bus.mem_r_data, lo_q};
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          addr_d  = addr_q + TWO;
          rem_d   = rem_q - ONE;
          if (rem_q == ONE) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            raddr_d = addr_q + TWO;
            state_d = RD_LO;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      raddr_q <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      raddr_q <= raddr_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_r_addr = raddr_q;
  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule
